// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: shadow-stage record, FSM states,
// operand-forwarding source encodings.
package cpu_pipe_pkg;

   localparam int RF_AW = 3;

   typedef struct packed {
      logic             valid;
      logic             wr;
      logic [RF_AW-1:0] rd;
      logic             load;
   } stage_info_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hctl_state_e;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   function automatic stage_info_t stage_empty();
      stage_info_t s;
      s.valid = 1'b0;
      s.wr    = 1'b0;
      s.rd    = {RF_AW{1'b0}};
      s.load  = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_raw_hazard_cmp.sv
// Read-after-write comparator: one shadow stage against one source operand of the ID instruction.
module raw_hazard_cmp
   import cpu_pipe_pkg::*;
(
   input  stage_info_t      stage,
   input  logic [RF_AW-1:0] rs,
   input  logic             rs_used,
   output logic             hit
);

   assign hit = stage.valid & stage.wr & rs_used & (stage.rd == rs);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: shadow EX/MEM/WB destinations, stall/bubble/flush, HALT drain.
// Define FORWARD_EN to enable EX operand forwarding (only load-use stalls remain).
module pipe_hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int REG_AW = RF_AW,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              Reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wr,
   input  logic              id_is_load,
   input  logic              id_is_halt,
   input  logic              ex_branch_taken,
   output logic              pc_load_en,
   output logic              ir_load_en,
   output logic              flush_id,
   output logic              bubble_ex,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   stage_info_t ex_q, mem_q, wb_q;
   stage_info_t ex_d, mem_d, wb_d;
   stage_info_t stg [3];
   hctl_state_e state_q, state_d;
   logic        halted_q;
   logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic [2:0]  raw_a, raw_b;
   logic        stall_hit, stall, branch, halt_go;

   assign stg[0] = ex_q;
   assign stg[1] = mem_q;
   assign stg[2] = wb_q;

   // Index 0 = EX, 1 = MEM, 2 = WB for both operand comparators.
   for (genvar g = 0; g < 3; g++) begin : g_cmp
      raw_hazard_cmp u_cmp_a (.stage(stg[g]), .rs(id_rs1), .rs_used(id_rs1_used), .hit(raw_a[g]));
      raw_hazard_cmp u_cmp_b (.stage(stg[g]), .rs(id_rs2), .rs_used(id_rs2_used), .hit(raw_b[g]));
   end

`ifdef FORWARD_EN
   assign stall_hit = id_valid & ex_q.load & (raw_a[0] | raw_b[0]);
`else
   assign stall_hit = id_valid & ((|raw_a) | (|raw_b));
`endif

   always_comb begin
      pc_load_en = 1'b0;
      ir_load_en = 1'b0;
      flush_id   = 1'b0;
      bubble_ex  = 1'b1;
      stall      = 1'b0;
      branch     = 1'b0;
      halt_go    = 1'b0;
      if (Reset) begin
         flush_id = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               // Branch beats stall: the squashed ID instruction cannot cause a hazard.
               if (ex_branch_taken) begin
                  branch     = 1'b1;
                  flush_id   = 1'b1;
                  pc_load_en = 1'b1;
                  ir_load_en = 1'b1;
               end else if (stall_hit) begin
                  stall = 1'b1;
               end else begin
                  pc_load_en = 1'b1;
                  ir_load_en = 1'b1;
                  bubble_ex  = 1'b0;
                  halt_go    = id_valid & id_is_halt;
               end
            end
            DRAIN:   pc_load_en = 1'b0;
            HALTED:  pc_load_en = 1'b0;
            default: pc_load_en = 1'b0;
         endcase
      end
   end

   always_comb begin
      ex_d.valid = id_valid & ~bubble_ex;
      ex_d.wr    = id_wr;
      ex_d.rd    = id_rd;
      ex_d.load  = id_is_load;
      mem_d      = ex_q;
      wb_d       = mem_q;

      state_d = state_q;
      case (state_q)
         RUN: begin
            if (halt_go) state_d = DRAIN;
            else         state_d = RUN;
         end
         // Look at next-cycle shadows so HALTED coincides with an empty pipe.
         DRAIN: begin
            if (!ex_d.valid && !mem_d.valid && !wb_d.valid) state_d = HALTED;
            else                                             state_d = DRAIN;
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase

      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                         stall_cnt_d = stall_cnt_q;
      if (branch && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                          flush_cnt_d = flush_cnt_q;

      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
`ifdef FORWARD_EN
      // Youngest producer wins; a WB producer is already visible in the register file.
      if (ex_d.valid) begin
         if (raw_a[0])      fwd_a_d = FWD_MEM;
         else if (raw_a[1]) fwd_a_d = FWD_WB;
         else               fwd_a_d = FWD_RF;
         if (raw_b[0])      fwd_b_d = FWD_MEM;
         else if (raw_b[1]) fwd_b_d = FWD_WB;
         else               fwd_b_d = FWD_RF;
      end else begin
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         ex_q        <= stage_empty();
         mem_q       <= stage_empty();
         wb_q        <= stage_empty();
         state_q     <= RUN;
         halted_q    <= 1'b0;
         fwd_a_q     <= FWD_RF;
         fwd_b_q     <= FWD_RF;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         state_q     <= state_d;
         halted_q    <= (state_d == HALTED);
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halted    = halted_q;
   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow FORWARD_EN when it is defined.
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        Reset;
   logic        id_valid;
   logic [2:0]  id_rs1, id_rs2, id_rd;
   logic        id_rs1_used, id_rs2_used, id_wr, id_is_load, id_is_halt;
   logic        ex_branch_taken;
   logic        pc_load_en, ir_load_en, flush_id, bubble_ex, halted;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] stall_cnt, flush_cnt;

   int tests;
   int fails;

`ifdef FORWARD_EN
   localparam int T1_STALLS = 0;
   localparam int T1_FWD    = 1;
   localparam int T2_STALLS = 1;
   localparam int T2_FWD_A  = 2;
`else
   localparam int T1_STALLS = 3;
   localparam int T1_FWD    = 0;
   localparam int T2_STALLS = 3;
   localparam int T2_FWD_A  = 0;
`endif

   pipe_hazard_ctrl dut (
      .clk(clk), .Reset(Reset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
      .ex_branch_taken(ex_branch_taken),
      .pc_load_en(pc_load_en), .ir_load_en(ir_load_en), .flush_id(flush_id),
      .bubble_ex(bubble_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      id_rd = 3'd0; id_wr = 1'b0; id_is_load = 1'b0; id_is_halt = 1'b0; ex_branch_taken = 1'b0;
   endtask

   task automatic set_id(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2, input logic u2,
                         input logic [2:0] rd, input logic wr, input logic ld, input logic hlt);
      id_valid = 1'b1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_wr = wr; id_is_load = ld; id_is_halt = hlt;
   endtask

   initial begin
      tests = 0; fails = 0; clk = 1'b0; Reset = 1'b1;
      set_idle();
      #2;
      chk("rst_pc", {31'd0, pc_load_en}, 32'd0);
      chk("rst_ir", {31'd0, ir_load_en}, 32'd0);
      chk("rst_flush", {31'd0, flush_id}, 32'd1);
      chk("rst_bubble", {31'd0, bubble_ex}, 32'd1);
      tick(); tick();
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
      chk("rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
      Reset = 1'b0;
      #1;
      chk("run_pc", {31'd0, pc_load_en}, 32'd1);
      chk("run_ir", {31'd0, ir_load_en}, 32'd1);
      chk("run_flush", {31'd0, flush_id}, 32'd0);
      chk("run_bubble", {31'd0, bubble_ex}, 32'd0);

      // T1: ADD R1,R2,R3 ; ADD R4,R1,R1
      tick();
      set_id(3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      #1 chk("t1_prod_pc", {31'd0, pc_load_en}, 32'd1);
      tick();
      set_id(3'd1, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < T1_STALLS; i++) begin
         chk("t1_stall_pc", {31'd0, pc_load_en}, 32'd0);
         chk("t1_stall_bubble", {31'd0, bubble_ex}, 32'd1);
         tick();
      end
      chk("t1_go_pc", {31'd0, pc_load_en}, 32'd1);
      chk("t1_go_bubble", {31'd0, bubble_ex}, 32'd0);
      tick();
      set_idle();
      #1;
      chk("t1_fwd_a", {30'd0, fwd_a_sel}, T1_FWD);
      chk("t1_fwd_b", {30'd0, fwd_b_sel}, T1_FWD);
      chk("t1_stall_cnt", {16'd0, stall_cnt}, T1_STALLS);
      tick(); tick(); tick();

      // T2: LDR R2,[R0] ; ADD R3,R2,R1
      set_id(3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
      #1 chk("t2_ld_pc", {31'd0, pc_load_en}, 32'd1);
      tick();
      set_id(3'd2, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < T2_STALLS; i++) begin
         chk("t2_stall_pc", {31'd0, pc_load_en}, 32'd0);
         chk("t2_stall_ir", {31'd0, ir_load_en}, 32'd0);
         tick();
      end
      chk("t2_go_pc", {31'd0, pc_load_en}, 32'd1);
      tick();
      set_idle();
      #1;
      chk("t2_fwd_a", {30'd0, fwd_a_sel}, T2_FWD_A);
      chk("t2_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
      chk("t2_stall_cnt", {16'd0, stall_cnt}, T1_STALLS + T2_STALLS);
      tick(); tick(); tick();

      // T3: branch in the same cycle as a load-use hazard
      set_id(3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(3'd2, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      ex_branch_taken = 1'b1;
      #1;
      chk("t3_flush", {31'd0, flush_id}, 32'd1);
      chk("t3_pc", {31'd0, pc_load_en}, 32'd1);
      chk("t3_ir", {31'd0, ir_load_en}, 32'd1);
      chk("t3_bubble", {31'd0, bubble_ex}, 32'd1);
      tick();
      chk("t3_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      chk("t3_stall_cnt", {16'd0, stall_cnt}, T1_STALLS + T2_STALLS);
      set_id(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      ex_branch_taken = 1'b0;
      #1 chk("t3_squashed_pc", {31'd0, pc_load_en}, 32'd1);
      tick();
      set_idle();
      tick(); tick(); tick();

      // T5: HALT squashed by a branch
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      ex_branch_taken = 1'b1;
      #1 chk("t5_flush", {31'd0, flush_id}, 32'd1);
      tick();
      set_idle();
      #1;
      chk("t5_run_pc", {31'd0, pc_load_en}, 32'd1);
      chk("t5_halted", {31'd0, halted}, 32'd0);
      chk("t5_flush_cnt", {16'd0, flush_cnt}, 32'd2);
      tick();
      chk("t5_run_pc2", {31'd0, pc_load_en}, 32'd1);
      chk("t5_halted2", {31'd0, halted}, 32'd0);

      // T4: ADD R5,R1,R2 ; HALT -> 3 drain cycles, then halted
      set_id(3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
      #1 chk("t4_add_pc", {31'd0, pc_load_en}, 32'd1);
      tick();
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      #1 chk("t4_halt_id_pc", {31'd0, pc_load_en}, 32'd1);
      tick();
      set_idle();
      for (int i = 0; i < 3; i++) begin
         chk("t4_drain_pc", {31'd0, pc_load_en}, 32'd0);
         chk("t4_drain_ir", {31'd0, ir_load_en}, 32'd0);
         chk("t4_drain_bubble", {31'd0, bubble_ex}, 32'd1);
         chk("t4_drain_halted", {31'd0, halted}, 32'd0);
         tick();
      end
      chk("t4_halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         ex_branch_taken = (i == 5);
         #1;
         chk("t4_hold_halted", {31'd0, halted}, 32'd1);
         chk("t4_hold_pc", {31'd0, pc_load_en}, 32'd0);
         tick();
      end
      ex_branch_taken = 1'b0;
      chk("t4_flush_cnt_frozen", {16'd0, flush_cnt}, 32'd2);

      // T6: Reset in the middle of a drain
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      #1 chk("t6_pre_pc", {31'd0, pc_load_en}, 32'd1);
      ex_branch_taken = 1'b1;
      tick();
      ex_branch_taken = 1'b0;
      chk("t6_pre_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      set_idle();
      #1 chk("t6_in_drain_pc", {31'd0, pc_load_en}, 32'd0);
      Reset = 1'b1;
      #1;
      chk("t6_rst_flush", {31'd0, flush_id}, 32'd1);
      chk("t6_rst_bubble", {31'd0, bubble_ex}, 32'd1);
      tick();
      Reset = 1'b0;
      set_id(3'd6, 1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
      #1;
      chk("t6_run_pc", {31'd0, pc_load_en}, 32'd1);
      chk("t6_halted", {31'd0, halted}, 32'd0);
      chk("t6_flush_cnt", {16'd0, flush_cnt}, 32'd0);
      chk("t6_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      tick();
      set_idle();
      #1;
      chk("t6_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
      chk("t6_fwd_b", {30'd0, fwd_b_sel}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
